parking_occupancy: RTL and testbench

Tracks lot occupancy and runs the entry gate. Sits directly downstream of the entry and exit sensor FSMs: it consumes their car-passed indications (`car_in` from the entry detector, `car_out` from the exit detector's `y`) and maintains a saturating car count with full/empty flags and sticky error flags. It also runs a small entry-gate FSM that opens on a driver request only while the lot has space, and closes on car passage or timeout.

---
 rtl/parking_occupancy_pkg.sv | 6 +
 rtl/parking_occupancy_if.sv | 11 +
 rtl/parking_occupancy_pulse_rise.sv | 13 +
 rtl/parking_occupancy.sv | 61 ++++++
 tb/tb_parking_occupancy.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/parking_occupancy_pkg.sv
// parking_pkg: shared gate FSM state type and default lot parameters
package parking_pkg;
  localparam int DEF_CAPACITY = 16;
  localparam int DEF_GATE_TIMEOUT = 8;
  typedef enum logic [1:0] {CLOSED = 2'b00, OPEN = 2'b01, HOLD = 2'b10} gate_state_t;
endpackage

// File: rtl/parking_occupancy_if.sv
// parking_occupancy_if: sensor/request inputs (car_in, car_out, gate_req, clr_err) and occupancy/gate/error outputs
interface parking_occupancy_if import parking_pkg::*; #(parameter int CAPACITY = DEF_CAPACITY);
  localparam int CNT_W = $clog2(CAPACITY + 1);
  logic car_in, car_out, gate_req, clr_err;
  logic [CNT_W-1:0] count;
  logic full, empty, gate_open, denied, err_over, err_under;
  modport master(output car_in, car_out, gate_req, clr_err,
                 input count, full, empty, gate_open, denied, err_over, err_under);
  modport slave(input car_in, car_out, gate_req, clr_err,
                output count, full, empty, gate_open, denied, err_over, err_under);
endinterface

// File: rtl/parking_occupancy_pulse_rise.sv
// pulse_rise: one-flop rising-edge detector (clk, reset_n, d in; rise out)
module pulse_rise (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);
  logic d_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) d_q <= 1'b0;
    else d_q <= d;
  assign rise = d & ~d_q;
endmodule

// File: rtl/parking_occupancy.sv
// parking_occupancy: saturating lot counter with sticky errors and entry-gate FSM (clk, reset_n, bus: parking_occupancy_if.slave)
module parking_occupancy import parking_pkg::*; #(
  parameter int CAPACITY = DEF_CAPACITY,
  parameter int GATE_TIMEOUT = DEF_GATE_TIMEOUT
) (
  input logic clk,
  input logic reset_n,
  parking_occupancy_if.slave bus
);
  localparam int CNT_W = $clog2(CAPACITY + 1);
  localparam int TMR_W = GATE_TIMEOUT > 1 ? $clog2(GATE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_TIMEOUT - 1);
  logic in_ev, out_ev, inc, dec, over, under, err_over, err_under;
  logic [CNT_W-1:0] count;
  logic [TMR_W-1:0] timer;
  gate_state_t state;
  pulse_rise u_in (.clk, .reset_n, .d(bus.car_in), .rise(in_ev));
  pulse_rise u_out (.clk, .reset_n, .d(bus.car_out), .rise(out_ev));
  always_comb begin
    inc = in_ev & ~out_ev & (count != CAP);
    over = in_ev & ~out_ev & (count == CAP);
    dec = out_ev & ~in_ev & (count != '0);
    under = out_ev & ~in_ev & (count == '0);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      count <= '0;
      err_over <= 1'b0;
      err_under <= 1'b0;
    end else begin
      count <= inc ? count + 1'b1 : dec ? count - 1'b1 : count;
      err_over <= over | (err_over & ~bus.clr_err);
      err_under <= under | (err_under & ~bus.clr_err);
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= CLOSED;
      timer <= '0;
    end else begin
      case (state)
        CLOSED:
          if (bus.gate_req & ~bus.full) begin
            state <= OPEN;
            timer <= TMR_LOAD;
          end else if (bus.gate_req) state <= HOLD;
        OPEN:
          if (in_ev || timer == '0) state <= HOLD;
          else timer <= timer - 1'b1;
        HOLD: if (!bus.gate_req) state <= CLOSED;
        default: state <= CLOSED;
      endcase
    end
  assign bus.count = count;
  assign bus.full = count == CAP;
  assign bus.empty = count == '0;
  assign bus.gate_open = state == OPEN;
  assign bus.denied = (state == CLOSED) & bus.gate_req & bus.full;
  assign bus.err_over = err_over;
  assign bus.err_under = err_under;
endmodule

// File: tb/tb_parking_occupancy.sv
// tb_parking_occupancy: randomized + directed check of two lot sizes against a behavioural occupancy/gate model
module tb_parking_occupancy;
  localparam int T = 8;
  logic clk = 1'b0, reset_n = 1'b0;
  logic car_in = 1'b0, car_out = 1'b0, gate_req = 1'b0, clr_err = 1'b0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  parking_occupancy_if #(.CAPACITY(4)) bus_a ();
  parking_occupancy_if #(.CAPACITY(16)) bus_b ();
  assign bus_a.car_in = car_in;
  assign bus_a.car_out = car_out;
  assign bus_a.gate_req = gate_req;
  assign bus_a.clr_err = clr_err;
  assign bus_b.car_in = car_in;
  assign bus_b.car_out = car_out;
  assign bus_b.gate_req = gate_req;
  assign bus_b.clr_err = clr_err;
  parking_occupancy #(.CAPACITY(4), .GATE_TIMEOUT(T)) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
  parking_occupancy #(.CAPACITY(16), .GATE_TIMEOUT(T)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));
  logic [4:0] cnt_d [2];
  logic [5:0] flg_d [2];
  assign cnt_d[0] = 5'(bus_a.count);
  assign cnt_d[1] = 5'(bus_b.count);
  assign flg_d[0] = {bus_a.full, bus_a.empty, bus_a.gate_open, bus_a.denied, bus_a.err_over, bus_a.err_under};
  assign flg_d[1] = {bus_b.full, bus_b.empty, bus_b.gate_open, bus_b.denied, bus_b.err_over, bus_b.err_under};
  // model: st 0=closed 1=open 2=hold; left = open cycles remaining
  int m_cnt [2], m_st [2], m_left [2];
  bit m_eo [2], m_eu [2];
  bit p_in, p_out, ie, oe, fpre, ov, un;
  function automatic int cap(int k);
    return k == 0 ? 4 : 16;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_step();
    if (!reset_n) begin
      p_in = 0;
      p_out = 0;
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0; m_st[k] = 0; m_left[k] = 0; m_eo[k] = 0; m_eu[k] = 0;
      end
    end else begin
      ie = car_in && !p_in;
      oe = car_out && !p_out;
      for (int k = 0; k < 2; k++) begin
        fpre = m_cnt[k] == cap(k);
        ov = ie && !oe && fpre;
        un = oe && !ie && m_cnt[k] == 0;
        if (m_st[k] == 0 && gate_req) begin
          if (fpre) m_st[k] = 2;
          else begin m_st[k] = 1; m_left[k] = T; end
        end else if (m_st[k] == 1) begin
          m_left[k]--;
          if (ie || m_left[k] == 0) m_st[k] = 2;
        end else if (m_st[k] == 2 && !gate_req) m_st[k] = 0;
        if (ie && !oe && !fpre) m_cnt[k]++;
        else if (oe && !ie && m_cnt[k] > 0) m_cnt[k]--;
        m_eo[k] = ov || (m_eo[k] && !clr_err);
        m_eu[k] = un || (m_eu[k] && !clr_err);
      end
      p_in = car_in;
      p_out = car_out;
    end
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
    #2;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("count[%0d]", k), 32'(cnt_d[k]), 32'(m_cnt[k]));
      chk($sformatf("flags[%0d]", k), 32'(flg_d[k]),
          32'({m_cnt[k] == cap(k), m_cnt[k] == 0, m_st[k] == 1,
               m_st[k] == 0 && gate_req && m_cnt[k] == cap(k), m_eo[k], m_eu[k]}));
    end
  end
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_in();
    car_in = 1; cyc(1); car_in = 0; cyc(1);
  endtask
  int wid [3] = '{1, 2, 4};
  int opens_a, opens_b, den_a;
  initial begin
    cyc(1);
    chk("rst_count_a", 32'(bus_a.count), 0);
    chk("rst_flags_a", 32'(flg_d[0]), 32'b010000);
    chk("rst_flags_b", 32'(flg_d[1]), 32'b010000);
    cyc(1);
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      car_in = 1; cyc(wid[i]); car_in = 0; cyc(1);
      chk("pulse_count_b", 32'(bus_b.count), 32'(i + 1));
      chk("pulse_empty_b", 32'(bus_b.empty), 0);
    end
    pulse_in();
    chk("fill_count_a", 32'(bus_a.count), 4);
    chk("fill_full_a", 32'(bus_a.full), 1);
    pulse_in();
    chk("over_count_a", 32'(bus_a.count), 4);
    chk("over_err_a", 32'(bus_a.err_over), 1);
    chk("over_count_b", 32'(bus_b.count), 5);
    chk("over_err_b", 32'(bus_b.err_over), 0);
    clr_err = 1; cyc(1); clr_err = 0;
    chk("clr_err_a", 32'(bus_a.err_over), 0);
    car_in = 1; car_out = 1; cyc(1); car_in = 0; car_out = 0; cyc(1);
    chk("both_count_a", 32'(bus_a.count), 4);
    chk("both_err_a", 32'({bus_a.err_over, bus_a.err_under}), 0);
    chk("both_count_b", 32'(bus_b.count), 5);
    gate_req = 1; #1;
    chk("deny_a", 32'(bus_a.denied), 1);
    chk("nodeny_b", 32'(bus_b.denied), 0);
    opens_a = 0; opens_b = 0; den_a = 0;
    repeat (12) begin
      cyc(1);
      opens_a += 32'(bus_a.gate_open);
      opens_b += 32'(bus_b.gate_open);
      den_a += 32'(bus_a.denied);
    end
    chk("timeout_open_b", 32'(opens_b), T);
    chk("full_open_a", 32'(opens_a), 0);
    chk("deny_once_a", 32'(den_a), 0);
    gate_req = 0; cyc(2);
    car_out = 1; cyc(1); car_out = 0; cyc(1);
    chk("exit_count_a", 32'(bus_a.count), 3);
    gate_req = 1; cyc(1);
    chk("open_a", 32'(bus_a.gate_open), 1);
    chk("open_b", 32'(bus_b.gate_open), 1);
    cyc(2);
    car_in = 1; cyc(1); car_in = 0;
    chk("pass_close_a", 32'(bus_a.gate_open), 0);
    chk("pass_count_a", 32'(bus_a.count), 4);
    chk("pass_count_b", 32'(bus_b.count), 5);
    cyc(3);
    chk("hold_a", 32'(bus_a.gate_open), 0);
    chk("hold_b", 32'(bus_b.gate_open), 0);
    gate_req = 0; cyc(1);
    gate_req = 1; cyc(1);
    chk("reopen_b", 32'(bus_b.gate_open), 1);
    chk("reopen_count_b", 32'(bus_b.count), 5);
    #1 reset_n = 0; #1;
    chk("async_rst_gate_b", 32'(bus_b.gate_open), 0);
    chk("async_rst_count_b", 32'(bus_b.count), 0);
    gate_req = 0; cyc(1);
    reset_n = 1;
    for (int i = 0; i < 4000; i++) begin
      cyc(1);
      if ($urandom_range(0, (i / 1000) % 2 == 0 ? 1 : 3) == 0) car_in = ~car_in;
      if ($urandom_range(0, (i / 1000) % 2 == 0 ? 3 : 1) == 0) car_out = ~car_out;
      if ($urandom_range(0, 5) == 0) gate_req = ~gate_req;
      clr_err = $urandom_range(0, 19) == 0;
      reset_n = $urandom_range(0, 799) != 0;
    end
    cyc(1);
    reset_n = 1;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
